// File: rtl/ysyx_23060240_sram_rd_arbiter.sv
// Two-master AXI4-Lite read-channel arbiter (IFU=M0, LSU=M1) onto one SRAM read port, one read in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority with M1 winning ties.
module ysyx_23060240_sram_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              s_rready,
    output logic [1:0]        grant
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a master holds valid and payload stable until then.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_AR = 2'd1,
        WAIT_R  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        grant_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              arvalid_nxt;
    logic              win0, win1;

`ifdef ARB_ROUND_ROBIN_EN
    // last_m1 = 1 when M1 was the most recent master accepted.
    logic last_m1, last_m1_nxt;
    assign win1 = m1_arvalid && (!m0_arvalid || !last_m1);
`else
    assign win1 = m1_arvalid;
`endif
    assign win0 = m0_arvalid && !win1;

    assign s_araddr = addr_q;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        addr_nxt    = addr_q;
        arvalid_nxt = s_arvalid;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;
        s_rready    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_m1_nxt = last_m1;
`endif
        case (state)
            IDLE: begin
                // Ready is withheld during reset so no request is accepted then dropped.
                if (rst_n) begin
                    m0_arready = win0;
                    m1_arready = win1;
                    if (win0 || win1) begin
                        state_nxt   = SEND_AR;
                        grant_nxt   = {win1, win0};
                        addr_nxt    = win1 ? m1_araddr : m0_araddr;
                        arvalid_nxt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_m1_nxt = win1;
`endif
                    end
                end
            end
            SEND_AR: begin
                if (s_arready) begin
                    state_nxt   = WAIT_R;
                    arvalid_nxt = 1'b0;
                end
            end
            WAIT_R: begin
                if (grant[1]) begin
                    s_rready  = m1_rready;
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                end else if (grant[0]) begin
                    s_rready  = m0_rready;
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                end
                if (s_rvalid && s_rready) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                end
            end
            default: begin
                state_nxt   = IDLE;
                grant_nxt   = 2'b00;
                arvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 2'b00;
            addr_q    <= '0;
            s_arvalid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_m1   <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            addr_q    <= addr_nxt;
            s_arvalid <= arvalid_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_m1   <= last_m1_nxt;
`endif
        end
    end

`ifndef SYNTHESIS
    // The SRAM may only present read data while a read is outstanding.
    spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        s_rvalid |-> (state == WAIT_R));
`endif

endmodule
